// File: rtl/top.sv
// Multi-cycle RV32I core: FETCH/DECODE/EXEC/MEM/MEMWR/WB.
// Instruction and data memories are external and synchronous (one-cycle read latency).

module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd
);
    logic [31:0] mem [0:31];

    // register array; x0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (i_we && (i_wa != 5'd0)) begin
            mem[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : mem[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : mem[i_ra2];
endmodule

module cpu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_im_out,
    input  logic [31:0] i_dm_out,
    output logic        o_im_enable,
    output logic [31:0] o_im_address,
    output logic        o_dm_enable,
    output logic        o_dm_write,
    output logic [31:0] o_dm_in,
    output logic [31:0] o_dm_address
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_MEMWR  = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    state_t      r_state, w_next_state;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_next_pc, r_addr;
    logic        r_wb_en, r_load, r_sw;
    logic [31:0] w_rs1_data, w_rs2_data, w_alu, w_next_pc, w_addr, w_wb_data, w_merge;
    logic        w_wb_en, w_load, w_store, w_rf_we;
    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    function automatic logic [31:0] alu_f(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] y;
        case (f3)
            3'b000: y = alt ? (a - b) : (a + b);
            3'b001: y = a << b[4:0];
            3'b010: y = {31'd0, ($signed(a) < $signed(b))};
            3'b011: y = {31'd0, (a < b)};
            3'b100: y = a ^ b;
            3'b101: begin
                if (alt) y = $unsigned($signed(a) >>> b[4:0]);
                else     y = a >> b[4:0];
            end
            3'b110: y = a | b;
            3'b111: y = a & b;
            default: y = 32'd0;
        endcase
        return y;
    endfunction

    function automatic logic br_f(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic y;
        case (f3)
            3'b000: y = (a == b);
            3'b001: y = (a != b);
            3'b100: y = ($signed(a) < $signed(b));
            3'b101: y = ($signed(a) >= $signed(b));
            3'b110: y = (a < b);
            3'b111: y = (a >= b);
            default: y = 1'b0;
        endcase
        return y;
    endfunction

    // little-endian lane extraction with sign/zero extension
    function automatic logic [31:0] load_f(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] y;
        case (lane)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000: y = {{24{b[7]}}, b};
            3'b001: y = {{16{h[15]}}, h};
            3'b100: y = {24'd0, b};
            3'b101: y = {16'd0, h};
            default: y = word;
        endcase
        return y;
    endfunction

    function automatic logic [31:0] merge_f(input logic [2:0] f3, input logic [1:0] lane,
                                            input logic [31:0] old, input logic [15:0] val);
        logic [31:0] y;
        y = old;
        if (f3 == 3'b000) begin
            case (lane)
                2'd0: y[7:0]   = val[7:0];
                2'd1: y[15:8]  = val[7:0];
                2'd2: y[23:16] = val[7:0];
                default: y[31:24] = val[7:0];
            endcase
        end else if (lane[1]) begin
            y[31:16] = val;
        end else begin
            y[15:0] = val;
        end
        return y;
    endfunction

    assign w_opcode = r_ir[6:0];
    assign w_f3     = r_ir[14:12];
    assign w_imm_i  = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s  = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b  = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_u  = {r_ir[31:12], 12'd0};
    assign w_imm_j  = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

    // rs1/rs2 are read straight from the fetched word during DECODE
    regfile RF1 (
        .clk   (clk),
        .rst   (rst),
        .i_ra1 (i_im_out[19:15]),
        .i_ra2 (i_im_out[24:20]),
        .o_rd1 (w_rs1_data),
        .o_rd2 (w_rs2_data),
        .i_we  (w_rf_we),
        .i_wa  (r_ir[11:7]),
        .i_wd  (w_wb_data)
    );

    // execute-stage datapath: result, target and memory address
    always_comb begin
        w_alu     = 32'd0;
        w_next_pc = r_pc + 32'd4;
        w_addr    = r_a + w_imm_i;
        w_wb_en   = 1'b0;
        w_load    = 1'b0;
        w_store   = 1'b0;
        case (w_opcode)
            OP_LUI: begin
                w_alu   = w_imm_u;
                w_wb_en = 1'b1;
            end
            OP_AUIPC: begin
                w_alu   = r_pc + w_imm_u;
                w_wb_en = 1'b1;
            end
            OP_JAL: begin
                w_alu     = r_pc + 32'd4;
                w_wb_en   = 1'b1;
                w_next_pc = r_pc + w_imm_j;
            end
            OP_JALR: begin
                w_alu     = r_pc + 32'd4;
                w_wb_en   = 1'b1;
                w_next_pc = (r_a + w_imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                if (br_f(w_f3, r_a, r_b)) w_next_pc = r_pc + w_imm_b;
                else                      w_next_pc = r_pc + 32'd4;
            end
            OP_LOAD: begin
                if ((w_f3 != 3'b011) && (w_f3[2:1] != 2'b11)) begin
                    w_load  = 1'b1;
                    w_wb_en = 1'b1;
                end else begin
                    w_load  = 1'b0;
                end
            end
            OP_STORE: begin
                w_addr = r_a + w_imm_s;
                if (w_f3 <= 3'b010) w_store = 1'b1;
                else                w_store = 1'b0;
            end
            OP_IMM: begin
                w_alu   = alu_f(w_f3, (w_f3 == 3'b101) & r_ir[30], r_a, w_imm_i);
                w_wb_en = 1'b1;
            end
            OP_OP: begin
                w_alu   = alu_f(w_f3, r_ir[30] & ((w_f3 == 3'b000) | (w_f3 == 3'b101)), r_a, r_b);
                w_wb_en = 1'b1;
            end
            default: w_wb_en = 1'b0;
        endcase
    end

    // next-state logic
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC: begin
                if (w_load || w_store) w_next_state = S_MEM;
                else                   w_next_state = S_WB;
            end
            S_MEM: begin
                if (r_load)    w_next_state = S_WB;
                else if (r_sw) w_next_state = S_FETCH;
                else           w_next_state = S_MEMWR;
            end
            S_MEMWR:  w_next_state = S_FETCH;
            S_WB:     w_next_state = S_FETCH;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // state, instruction and operand registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_pc      <= 32'd0;
            r_ir      <= 32'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_alu     <= 32'd0;
            r_next_pc <= 32'd0;
            r_addr    <= 32'd0;
            r_wb_en   <= 1'b0;
            r_load    <= 1'b0;
            r_sw      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_DECODE: begin
                    r_ir <= i_im_out;
                    r_a  <= w_rs1_data;
                    r_b  <= w_rs2_data;
                end
                S_EXEC: begin
                    r_alu     <= w_alu;
                    r_next_pc <= w_next_pc;
                    r_addr    <= w_addr;
                    r_wb_en   <= w_wb_en;
                    r_load    <= w_load;
                    r_sw      <= w_store & (w_f3 == 3'b010);
                end
                S_MEM: begin
                    if (r_sw) r_pc <= r_next_pc;
                end
                S_MEMWR: r_pc <= r_next_pc;
                S_WB:    r_pc <= r_next_pc;
                default: r_pc <= r_pc;
            endcase
        end
    end

    assign w_merge   = merge_f(w_f3, r_addr[1:0], i_dm_out, r_b[15:0]);
    assign w_wb_data = r_load ? load_f(w_f3, r_addr[1:0], i_dm_out) : r_alu;
    assign w_rf_we   = (r_state == S_WB) & r_wb_en;

    // strobes are qualified by reset so every output reads 0 while held in reset
    assign o_im_enable  = rst & (r_state == S_FETCH);
    assign o_im_address = r_pc;
    assign o_dm_enable  = rst & ((r_state == S_MEM) | (r_state == S_MEMWR));
    assign o_dm_write   = rst & (((r_state == S_MEM) & r_sw) | (r_state == S_MEMWR));
    assign o_dm_in      = (r_state == S_MEMWR) ? w_merge : r_b;
    assign o_dm_address = {r_addr[31:2], 2'b00};
endmodule

module top (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IM_out,
    input  logic [31:0] DM_out,
    output logic        IM_enable,
    output logic [31:0] IM_address,
    output logic        DM_enable,
    output logic        DM_write,
    output logic [31:0] DM_in,
    output logic [31:0] DM_address
);
    cpu CPU1 (
        .clk          (clk),
        .rst          (rst),
        .i_im_out     (IM_out),
        .i_dm_out     (DM_out),
        .o_im_enable  (IM_enable),
        .o_im_address (IM_address),
        .o_dm_enable  (DM_enable),
        .o_dm_write   (DM_write),
        .o_dm_in      (DM_in),
        .o_dm_address (DM_address)
    );
endmodule

// File: tb/tb_top.sv
// Directed bench for the multi-cycle RV32I core: synchronous memory models,
// a store scoreboard, per-instruction latency/PC checks and register checks.

module tb_top;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IM_out, DM_out;
    logic        IM_enable, DM_enable, DM_write;
    logic [31:0] IM_address, DM_in, DM_address;

    logic [31:0] im [0:65535];
    logic [31:0] dm [0:65535];
    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];
    int checks = 0;
    int errors = 0;

    localparam logic [6:0] OPI  = 7'b0010011;
    localparam logic [6:0] LOAD = 7'b0000011;

    top dut (
        .clk        (clk),
        .rst        (rst),
        .IM_out     (IM_out),
        .DM_out     (DM_out),
        .IM_enable  (IM_enable),
        .IM_address (IM_address),
        .DM_enable  (DM_enable),
        .DM_write   (DM_write),
        .DM_in      (DM_in),
        .DM_address (DM_address)
    );

    always #5 clk = ~clk;

    // synchronous instruction/data memories, one-cycle read latency
    always @(posedge clk) begin
        if (IM_enable) IM_out <= im[IM_address[17:2]];
        if (DM_enable) begin
            if (DM_write) dm[DM_address[17:2]] <= DM_in;
            else          DM_out <= dm[DM_address[17:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // store scoreboard: every memory write must match the next queued expectation
    always @(negedge clk) begin
        if (DM_enable && DM_write) begin
            checks++;
            assert (exp_addr_q.size() != 0) else begin
                errors++;
                $error("FAIL dm_unexpected_write: observed addr=%h data=%h expected no write",
                       DM_address, DM_in);
            end
            if (exp_addr_q.size() != 0) begin
                check("dm_wr_addr", DM_address, exp_addr_q.pop_front());
                check("dm_wr_data", DM_in, exp_data_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    // branch offset given in halfwords (byte offset / 2)
    function automatic logic [31:0] enc_b(input logic [11:0] offh, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {offh[11], offh[9:4], rs2, rs1, f3, offh[3:0], offh[10], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    // jump offset given in halfwords (byte offset / 2)
    function automatic logic [31:0] enc_j(input logic [19:0] offh, input logic [4:0] rd);
        return {offh[19], offh[9:0], offh[10], offh[18:11], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // from a FETCH cycle, count cycles to the next FETCH and check its address
    task automatic step(input string tag, input int exp_cyc, input logic [31:0] exp_pc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!IM_enable && n < 20);
        check({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
        check({tag, "_pc"}, IM_address, exp_pc);
    endtask

    function automatic logic [31:0] reg_or();
        logic [31:0] acc;
        acc = 32'd0;
        for (int i = 0; i < 32; i++) acc |= dut.CPU1.RF1.mem[i];
        return acc;
    endfunction

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    initial begin
        rst    = 1'b0;
        IM_out = 32'd0;
        DM_out = 32'd0;
        for (int i = 0; i < 65536; i++) begin
            im[i] = 32'd0;
            dm[i] = 32'd0;
        end
        im[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);              // addi x1,x0,5
        im[1]  = enc_i(12'd6, 5'd0, 3'b000, 5'd2, OPI);              // addi x2,x0,6
        im[2]  = enc_s(12'd16, 5'd2, 5'd0, 3'b010);                  // sw x2,16(x0)
        im[3]  = enc_u(20'h80FF0, 5'd6, 7'b0110111);                 // lui x6,0x80FF0
        im[4]  = enc_i(12'd6, 5'd6, 3'b000, 5'd6, OPI);              // addi x6,x6,6
        im[5]  = enc_s(12'd16, 5'd6, 5'd0, 3'b010);                  // sw x6,16(x0)
        im[6]  = enc_i(12'd17, 5'd0, 3'b000, 5'd3, LOAD);            // lb x3,17(x0)
        im[7]  = enc_i(12'd19, 5'd0, 3'b100, 5'd4, LOAD);            // lbu x4,19(x0)
        im[8]  = enc_i(12'd18, 5'd0, 3'b001, 5'd5, LOAD);            // lh x5,18(x0)
        im[9]  = enc_s(12'd19, 5'd2, 5'd0, 3'b000);                  // sb x2,19(x0)
        im[10] = enc_r(7'b0100000, 5'd1, 5'd4, 3'b000, 5'd7);        // sub x7,x4,x1
        im[11] = enc_i({7'b0100000, 5'd4}, 5'd5, 3'b101, 5'd8, OPI); // srai x8,x5,4
        im[12] = enc_r(7'd0, 5'd1, 5'd5, 3'b010, 5'd9);              // slt x9,x5,x1
        im[13] = enc_r(7'd0, 5'd1, 5'd5, 3'b011, 5'd10);             // sltu x10,x5,x1
        im[14] = enc_b(12'd4, 5'd0, 5'd0, 3'b000);                   // beq x0,x0,+8
        im[15] = enc_i(12'd1, 5'd0, 3'b000, 5'd11, OPI);             // skipped
        im[16] = enc_i(12'd7, 5'd0, 3'b000, 5'd0, OPI);              // addi x0,x0,7
        im[17] = enc_j(20'd6, 5'd12);                                // jal x12,+12
        im[18] = enc_i(12'd2, 5'd0, 3'b000, 5'd11, OPI);             // skipped
        im[19] = enc_i(12'd2, 5'd0, 3'b000, 5'd11, OPI);             // skipped
        im[20] = enc_i(12'd92, 5'd1, 3'b000, 5'd13, 7'b1100111);     // jalr x13,92(x1)
        im[21] = enc_i(12'd3, 5'd0, 3'b000, 5'd11, OPI);             // skipped
        im[22] = enc_i(12'd3, 5'd0, 3'b000, 5'd11, OPI);             // skipped
        im[23] = enc_i(12'd3, 5'd0, 3'b000, 5'd11, OPI);             // skipped
        im[24] = enc_b(12'd4, 5'd1, 5'd1, 3'b001);                   // bne x1,x1,+8
        im[25] = enc_s(12'd16, 5'd2, 5'd0, 3'b010);                  // sw x2,16(x0), reset hits it

        repeat (3) @(negedge clk);
        check("rst_im_enable", 32'(IM_enable), 32'd0);
        check("rst_dm_enable", 32'(DM_enable), 32'd0);
        check("rst_dm_write", 32'(DM_write), 32'd0);
        check("rst_im_address", IM_address, 32'd0);
        check("rst_dm_address", DM_address, 32'd0);
        check("rst_dm_in", DM_in, 32'd0);
        check("rst_regs", reg_or(), 32'd0);

        rst = 1'b1;
        #1;
        check("first_fetch_en", 32'(IM_enable), 32'd1);
        check("first_fetch_addr", IM_address, 32'd0);

        step("addi1", 4, 32'd4);
        check("x1", dut.CPU1.RF1.mem[1], 32'd5);
        step("addi2", 4, 32'd8);
        check("x2", dut.CPU1.RF1.mem[2], 32'd6);
        push_wr(32'h10, 32'd6);
        step("sw1", 4, 32'd12);
        check("dm4_sw1", dm[4], 32'h00000006);
        step("lui", 4, 32'd16);
        check("x6_lui", dut.CPU1.RF1.mem[6], 32'h80FF0000);
        step("addi6", 4, 32'd20);
        check("x6", dut.CPU1.RF1.mem[6], 32'h80FF0006);
        push_wr(32'h10, 32'h80FF0006);
        step("sw2", 4, 32'd24);
        check("dm4_sw2", dm[4], 32'h80FF0006);
        step("lb", 5, 32'd28);
        check("x3_lb", dut.CPU1.RF1.mem[3], 32'h00000000);
        step("lbu", 5, 32'd32);
        check("x4_lbu", dut.CPU1.RF1.mem[4], 32'h00000080);
        step("lh", 5, 32'd36);
        check("x5_lh", dut.CPU1.RF1.mem[5], 32'hFFFF80FF);
        push_wr(32'h10, 32'h06FF0006);
        step("sb", 5, 32'd40);
        check("dm4_sb", dm[4], 32'h06FF0006);
        step("sub", 4, 32'd44);
        check("x7_sub", dut.CPU1.RF1.mem[7], 32'h0000007B);
        step("srai", 4, 32'd48);
        check("x8_srai", dut.CPU1.RF1.mem[8], 32'hFFFFF80F);
        step("slt", 4, 32'd52);
        check("x9_slt", dut.CPU1.RF1.mem[9], 32'd1);
        step("sltu", 4, 32'd56);
        check("x10_sltu", dut.CPU1.RF1.mem[10], 32'd0);
        step("beq", 4, 32'd64);
        step("addi_x0", 4, 32'd68);
        check("x0", dut.CPU1.RF1.mem[0], 32'd0);
        check("x11_skipped", dut.CPU1.RF1.mem[11], 32'd0);
        step("jal", 4, 32'd80);
        check("x12_jal", dut.CPU1.RF1.mem[12], 32'd72);
        step("jalr", 4, 32'd96);
        check("x13_jalr", dut.CPU1.RF1.mem[13], 32'd84);
        step("bne", 4, 32'd100);

        // abort the store at address 100 while it sits in MEM
        repeat (3) @(posedge clk);
        #2;
        check("sw3_mem_write", 32'(DM_write), 32'd1);
        check("sw3_mem_addr", DM_address, 32'h10);
        rst = 1'b0;
        #1;
        check("abort_dm_enable", 32'(DM_enable), 32'd0);
        check("abort_dm_write", 32'(DM_write), 32'd0);
        check("abort_im_address", IM_address, 32'd0);
        check("abort_regs", reg_or(), 32'd0);
        repeat (2) @(negedge clk);
        check("abort_dm4", dm[4], 32'h06FF0006);
        rst = 1'b1;
        #1;
        check("refetch_en", 32'(IM_enable), 32'd1);
        check("refetch_addr", IM_address, 32'd0);
        step("post_rst_addi1", 4, 32'd4);
        check("x1_again", dut.CPU1.RF1.mem[1], 32'd5);
        check("wr_queue_empty", 32'(exp_addr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 top SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 IM_out  input  32  instruction word from the synchronous instruction memory, valid the cycle after a read request.
REQ-005 DM_out  input  32  data word from the synchronous data memory, valid the cycle after a read request.
REQ-006 IM_enable  output  1  instruction-memory access strobe.
REQ-007 IM_address  output  32  instruction byte address; memory uses bits [17:2].
REQ-008 DM_enable  output  1  data-memory access strobe.
REQ-009 DM_write  output  1  1 = write DM_in at DM_address while DM_enable=1; 0 = read.
REQ-010 DM_in  output  32  store data (full word).
REQ-011 DM_address  output  32  data byte address; memory uses bits [17:2].

Function
REQ-012 top SHALL contain instance CPU1, which SHALL contain register-file instance RF1 holding array mem[0:31] of 32-bit registers, hierarchically readable by the bench.
REQ-013 The core SHALL execute RV32I: LUI, AUIPC, JAL, JALR, all branches, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP instructions; any other opcode SHALL behave as a NOP (PC+4).
REQ-014 The core SHALL be a multi-cycle FSM with states FETCH, DECODE, EXEC, MEM, MEMWR, WB.
REQ-015 FETCH: IM_enable=1, IM_address=PC; the next state is DECODE.
REQ-016 DECODE: IR latched from IM_out; rs1/rs2 read; the next state is EXEC.
REQ-017 EXEC: ALU result, branch decision and target are computed; loads/stores go to MEM, all other instructions go to WB.
REQ-018 MEM, load or SB/SH: DM_enable=1, DM_write=0, DM_address = rs1+imm with bits [1:0] forced to 0.
REQ-019 MEM, SW: DM_enable=1, DM_write=1, DM_in=rs2; the next state is FETCH with PC+4.
REQ-020 MEMWR (SB/SH only): the byte/half of DM_out selected by addr[1:0] (little-endian) is merged with rs2, then written as a full word; the next state is FETCH.
REQ-021 WB: rd is written (loads extract and sign/zero-extend from DM_out by addr[1:0]); PC is updated; the next state is FETCH.
REQ-022 Latency SHALL be: ALU/branch/jump 4 cycles; LW/LB/LH/LBU/LHU 5 cycles; SW 4 cycles; SB/SH 5 cycles.
REQ-023 Writes to x0 SHALL be discarded; x0 SHALL always read 0.
REQ-024 Arithmetic SHALL wrap modulo 2^32; shifts SHALL use amount bits [4:0]; SLT/SLTI SHALL be signed; SLTU/SLTIU SHALL be unsigned.
REQ-025 JAL/JALR SHALL write PC+4 to rd; JALR target = (rs1+imm) with bit 0 cleared.
REQ-026 Misaligned LW/SW and LH/SH with addr[0]=1 SHALL use the word-aligned address; no trap.
REQ-027 IM_enable, DM_enable and DM_write SHALL be 0 in every state other than the state that asserts them.

Reset
REQ-028 While rst=0: PC=0, state=FETCH, all RF1.mem=0, IR=0, and all outputs=0.
REQ-029 Reset asserted mid-instruction SHALL abort it with no register or memory write; the first FETCH after release SHALL use address 0.

Verification
REQ-030 addi x1,x0,5 at address 0 -> after 4 cycles RF1.mem[1]=5, IM_address=4 in the next FETCH.
REQ-031 addi x2,x0,6; sw x2,16(x0) -> DM_write=1, DM_address=0x10, DM_in=6; DM word 4=0x00000006.
REQ-032 With DM word 4=0x80FF0006: lb x3,1(x0)... → use lb x3,17(x0) -> x3=0x00000000; lbu x4,19(x0) -> x4=0x80; lh x5,18(x0) -> x5=0xFFFF80FF.
REQ-033 sb of x2=0x6 to address 0x13 -> DM word 4=0x06FF0006 after the MEM/MEMWR pair.
REQ-034 beq x0,x0,+8 -> next FETCH address = PC+8; addi x0,x0,7 -> RF1.mem[0] stays 0.
REQ-035 rst pulsed low during MEM of a SW -> no DM write occurs; all registers read 0; the next IM_address=0.
